// File: rtl/interp_pkg.sv
// interp_pkg: reader FSM states and fixed-point constants shared with the bilinear stage
package interp_pkg;
    localparam int FRAC_WIDTH = 8;
    localparam int ONE_FP = 1 << FRAC_WIDTH;
    typedef enum logic [2:0] {IDLE, RD_X0, RD_X1, STALL, FLUSH, DRAIN} state_t;
endpackage

// File: rtl/interp_line_reader_if.sv
// interp_line_reader_if: valid/ready beat stream of neighbour pixel pairs and weight
interface interp_line_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = interp_pkg::FRAC_WIDTH
) ();
    logic valid;
    logic ready;
    logic [DATA_WIDTH-1:0] pix0;
    logic [DATA_WIDTH-1:0] pix1;
    logic [FRAC_WIDTH-1:0] frac;
    logic last;
    modport master (output valid, pix0, pix1, frac, last, input ready);
    modport slave (input valid, pix0, pix1, frac, last, output ready);
endinterface

// File: rtl/interp_line_reader.sv
// interp_line_reader: walks a fixed-point source position and streams clamped neighbour pairs
module interp_line_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = interp_pkg::FRAC_WIDTH
) (
    input  logic                             rd_clk,
    input  logic                             rd_rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            src_last,
    input  logic [ADDR_WIDTH-1:0]            out_last,
    input  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step,
    output logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0]            rd_data,
    interp_line_reader_if.master             m,
    output logic                             busy,
    output logic                             done
);
    import interp_pkg::*;

    localparam int POS_WIDTH = ADDR_WIDTH + FRAC_WIDTH;

    state_t state, state_n;
    logic [POS_WIDTH-1:0] pos, step_q;
    logic [POS_WIDTH:0] pos_sum;
    logic [ADDR_WIDTH-1:0] cnt, src_last_q, out_last_q, xi, x0, x1;
    logic [DATA_WIDTH-1:0] pix0_q;
    logic [FRAC_WIDTH-1:0] frac_q;
    logic pend, can_load, load;

    assign xi = pos[POS_WIDTH-1:FRAC_WIDTH];
    assign x0 = xi > src_last_q ? src_last_q : xi;
    assign x1 = x0 == src_last_q ? x0 : x0 + 1'b1;
    assign pos_sum = {1'b0, pos} + {1'b0, step_q};
    assign can_load = !m.valid || m.ready;
    assign busy = state != IDLE;

    // state register
    always_ff @(posedge rd_clk) begin
        if (rd_rst) state <= IDLE;
        else state <= state_n;
    end

    // next state and output-register load strobe
    always_comb begin
        state_n = state;
        load = 1'b0;
        case (state)
            IDLE: state_n = start ? RD_X0 : IDLE;
            RD_X0: begin
                state_n = RD_X1;
                load = pend;
            end
            RD_X1: state_n = cnt == out_last_q ? FLUSH : can_load ? RD_X0 : STALL;
            STALL: state_n = can_load ? RD_X0 : STALL;
            FLUSH: begin
                state_n = can_load ? DRAIN : FLUSH;
                load = can_load;
            end
            DRAIN: state_n = m.valid && m.ready ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    // address walk, pixel capture and output beat register
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_addr <= '0;
            pos <= '0;
            step_q <= '0;
            cnt <= '0;
            src_last_q <= '0;
            out_last_q <= '0;
            pix0_q <= '0;
            frac_q <= '0;
            pend <= 1'b0;
            done <= 1'b0;
            m.valid <= 1'b0;
            m.pix0 <= '0;
            m.pix1 <= '0;
            m.frac <= '0;
            m.last <= 1'b0;
        end else begin
            done <= state == DRAIN && m.valid && m.ready;
            if (m.valid && m.ready) m.valid <= 1'b0;
            if (load) begin
                m.valid <= 1'b1;
                m.pix0 <= pix0_q;
                m.pix1 <= rd_data;
                m.frac <= frac_q;
                m.last <= state == FLUSH;
                pend <= 1'b0;
            end
            case (state)
                IDLE: begin
                    rd_addr <= '0;
                    if (start) begin
                        src_last_q <= src_last;
                        out_last_q <= out_last;
                        step_q <= step;
                        pos <= '0;
                        cnt <= '0;
                    end
                end
                RD_X0: rd_addr <= x0;
                RD_X1: begin
                    rd_addr <= x1;
                    pix0_q <= rd_data;
                    frac_q <= pos[FRAC_WIDTH-1:0];
                    pend <= 1'b1;
                    pos <= pos_sum[POS_WIDTH] ? '1 : pos_sum[POS_WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_interp_line_reader.sv
// tb_interp_line_reader: randomized line reads checked against an arithmetic beat model
module tb_interp_line_reader;
    import interp_pkg::*;

    logic rd_clk = 1'b0;
    logic rd_rst = 1'b1;
    logic start = 1'b0;
    logic [10:0] src_last = '0;
    logic [10:0] out_last = '0;
    logic [18:0] step = '0;
    logic [10:0] rd_addr;
    logic [15:0] rd_data;
    logic busy, done;
    logic [15:0] mem [2048];
    logic [40:0] exp_q [$];
    logic [40:0] hold_b, e;
    logic hold_v = 1'b0;
    logic last_hs = 1'b0;
    logic have_e;
    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int rmode = 0;
    int addr_exp [8] = '{0, 1, 1, 2, 2, 3, 3, 3};

    interp_line_reader_if #(.DATA_WIDTH(16), .FRAC_WIDTH(8)) m_if ();

    interp_line_reader dut (
        .rd_clk(rd_clk),
        .rd_rst(rd_rst),
        .start(start),
        .src_last(src_last),
        .out_last(out_last),
        .step(step),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .m(m_if),
        .busy(busy),
        .done(done)
    );

    always #5 rd_clk = ~rd_clk;

    // the reader's rd_addr register is the RAM address register; array read follows it
    assign rd_data = mem[rd_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    endtask

    // expected beats straight from the position arithmetic: pos_k = min(k*step, all-ones)
    task automatic plan(input logic [10:0] sl, input logic [10:0] ol, input logic [18:0] st);
        for (int k = 0; k <= int'(ol); k++) begin
            longint p;
            int xi, x0, x1;
            p = longint'(k) * longint'(st);
            if (p > 64'h7FFFF) p = 64'h7FFFF;
            xi = int'(p >> 8);
            x0 = xi > int'(sl) ? int'(sl) : xi;
            x1 = x0 + 1 > int'(sl) ? int'(sl) : x0 + 1;
            exp_q.push_back({mem[x0], mem[x1], 8'(p), 1'(k == int'(ol))});
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge rd_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic start_line(input logic [10:0] sl, input logic [10:0] ol, input logic [18:0] st);
        plan(sl, ol, st);
        src_last = sl;
        out_last = ol;
        step = st;
        pulse_start();
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 5000) begin
            @(posedge rd_clk);
            n++;
        end
        #1;
        chk("done_count", 64'(done_cnt), 64'(target));
        chk("beats_left", 64'(exp_q.size()), 0);
    endtask

    task automatic run_line(input logic [10:0] sl, input logic [10:0] ol, input logic [18:0] st);
        int t = done_cnt + 1;
        start_line(sl, ol, st);
        wait_done(t);
    endtask

    // downstream ready: always, random, or held low for backpressure
    initial begin
        m_if.ready = 1'b1;
        forever begin
            @(posedge rd_clk);
            #2;
            m_if.ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 3) != 0) : 1'b0;
        end
    end

    // stream monitor: beat order/content, hold-while-stalled, done timing
    always @(negedge rd_clk) begin
        if (rd_rst) begin
            hold_v = 1'b0;
            last_hs = 1'b0;
        end else begin
            chk("done_pulse", 64'(done), 64'(last_hs));
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 64'(busy), 0);
            end
            if (hold_v)
                chk("hold", {m_if.valid, m_if.pix0, m_if.pix1, m_if.frac, m_if.last}, {1'b1, hold_b});
            if (m_if.valid && m_if.ready) begin
                have_e = exp_q.size() != 0;
                e = have_e ? exp_q.pop_front() : '0;
                chk("beat", {1'b1, m_if.pix0, m_if.pix1, m_if.frac, m_if.last}, {have_e, e});
            end
            last_hs = m_if.valid && m_if.ready && m_if.last;
            hold_v = m_if.valid && !m_if.ready;
            hold_b = {m_if.pix0, m_if.pix1, m_if.frac, m_if.last};
        end
    end

    initial begin
        int t;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("rst_valid", 64'(m_if.valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_addr", 64'(rd_addr), 0);
        chk("rst_beat", {m_if.pix0, m_if.pix1, m_if.frac, m_if.last}, 0);
        @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;
        // 1:1 copy with cycle-level timing
        mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
        t = done_cnt + 1;
        start_line(3, 3, 19'(ONE_FP));
        for (int c = 1; c <= 11; c++) begin
            @(negedge rd_clk);
            if (c >= 2 && c <= 9) chk("addr_seq", 64'(rd_addr), 64'(addr_exp[c-2]));
            chk("valid_seq", 64'(m_if.valid), 64'(c >= 4 && c % 2 == 0));
            chk("busy_seq", 64'(busy), 64'(c <= 10));
        end
        @(posedge rd_clk);
        #1;
        wait_done(t);
        // 2x upscale
        mem[0] = 100; mem[1] = 200;
        run_line(1, 3, 128);
        // backpressure after the first beat
        mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
        rmode = 2;
        t = done_cnt + 1;
        start_line(3, 3, 19'(ONE_FP));
        for (int c = 0; c < 20 && !m_if.valid; c++) @(negedge rd_clk);
        chk("bp_first_valid", 64'(m_if.valid), 1);
        for (int c = 0; c < 5; c++) @(negedge rd_clk);
        chk("bp_stall_addr", 64'(rd_addr), 2);
        chk("bp_stall_valid", 64'(m_if.valid), 1);
        chk("bp_no_done", 64'(done_cnt), 64'(t - 1));
        @(posedge rd_clk);
        #1;
        rmode = 0;
        wait_done(t);
        // downscale with right-edge clamp
        mem[0] = 1; mem[1] = 2; mem[2] = 3;
        run_line(2, 2, 512);
        // corners: single beat, single source pixel, zero step
        mem[0] = 77; mem[1] = 88;
        run_line(5, 0, 19'(ONE_FP));
        run_line(0, 3, 19'(ONE_FP));
        run_line(4, 2, 0);
        // start while busy is dropped
        t = done_cnt + 1;
        start_line(3, 5, 200);
        repeat (4) @(posedge rd_clk);
        #1;
        pulse_start();
        wait_done(t);
        repeat (8) @(posedge rd_clk);
        #1;
        chk("busy_start_ignored", 64'(busy), 0);
        chk("busy_start_done", 64'(done_cnt), 64'(t));
        // reset mid-line
        t = done_cnt;
        start_line(3, 20, 100);
        repeat (12) @(posedge rd_clk);
        #1;
        rd_rst = 1'b1;
        exp_q.delete();
        @(posedge rd_clk);
        @(negedge rd_clk);
        chk("midrst_valid", 64'(m_if.valid), 0);
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_done", 64'(done), 0);
        chk("midrst_addr", 64'(rd_addr), 0);
        chk("midrst_beat", {m_if.pix0, m_if.pix1, m_if.frac, m_if.last}, 0);
        @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;
        repeat (10) @(posedge rd_clk);
        #1;
        chk("midrst_no_done", 64'(done_cnt), 64'(t));
        // random lines with random backpressure
        rmode = 1;
        for (int n = 0; n < 30; n++) begin
            logic [10:0] sl, ol;
            logic [18:0] st;
            sl = 11'($urandom_range(0, 40));
            ol = 11'($urandom_range(0, 30));
            st = $urandom_range(0, 7) == 0 ? 19'h7FFFF : 19'($urandom_range(0, 1023));
            for (int i = 0; i <= int'(sl); i++) mem[i] = 16'($urandom_range(0, 65535));
            run_line(sl, ol, st);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
